// File: rtl/fan_tach_monitor.sv
// Per-fan tachometer pulse counter: synchronise, debounce, count rising edges per
// tick_1s window and publish a snapshot through a valid/ready port.
module fan_tach_monitor #(
  parameter int P_FAN_NUM     = 6,
  parameter int P_FILTER_LEN  = 4,
  parameter int P_COUNT_WIDTH = 16
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               en,
  input  logic                               tick_1s,
  input  logic [P_FAN_NUM-1:0]               fan_speed,
  output logic [P_FAN_NUM*P_COUNT_WIDTH-1:0] count_out,
  output logic [P_FAN_NUM-1:0]               count_stall,
  output logic [P_FAN_NUM-1:0]               count_ovf,
  output logic                               count_overrun,
  output logic                               count_valid,
  input  logic                               count_ready
);

  localparam int FW = $clog2(P_FILTER_LEN + 1);
  localparam int W  = P_COUNT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_e;

  state_e state_q, state_d;

  logic [P_FAN_NUM-1:0] sync1_q, sync2_q;
  logic [P_FAN_NUM-1:0] filt_q, filt_d, filt_dly_q, rise;
  logic [FW-1:0]        flt_cnt_q [P_FAN_NUM];
  logic [FW-1:0]        flt_cnt_d [P_FAN_NUM];

  logic [W-1:0]         acc_q   [P_FAN_NUM];
  logic [W-1:0]         acc_d   [P_FAN_NUM];
  logic [W-1:0]         acc_inc [P_FAN_NUM];
  logic [P_FAN_NUM-1:0] ovf_q, ovf_d, ovf_inc;

  logic [P_FAN_NUM*W-1:0] out_q, out_d;
  logic [P_FAN_NUM-1:0]   stall_q, stall_d, ovf_out_q, ovf_out_d;
  logic                   valid_q, valid_d, overrun_q, overrun_d;
  logic                   clear, publish, xfer;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < P_FAN_NUM; i++) begin
      filt_d[i]    = filt_q[i];
      flt_cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (flt_cnt_q[i] == FW'(P_FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else flt_cnt_d[i] = flt_cnt_q[i] + FW'(1);
      end
    end
  end

  assign rise = filt_q & ~filt_dly_q;

  // Saturating increment; an edge arriving at all-ones flags the window overflow.
  always_comb begin
    for (int i = 0; i < P_FAN_NUM; i++) begin
      acc_inc[i] = acc_q[i];
      ovf_inc[i] = ovf_q[i];
      if (rise[i]) begin
        if (&acc_q[i]) ovf_inc[i] = 1'b1;
        else acc_inc[i] = acc_q[i] + W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    publish = 1'b0;
    case (state_q)
      S_IDLE: begin
        clear = 1'b1;
        if (en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!en) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end else if (tick_1s) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end else if (tick_1s) begin
          publish = 1'b1;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < P_FAN_NUM; i++) acc_d[i] = clear ? '0 : acc_inc[i];
    ovf_d = clear ? '0 : ovf_inc;
  end

  // The publishing snapshot includes an edge landing on the tick cycle.
  assign xfer = valid_q & count_ready;

  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    out_d     = out_q;
    stall_d   = stall_q;
    ovf_out_d = ovf_out_q;
    if (publish) begin
      valid_d   = 1'b1;
      overrun_d = valid_q & ~count_ready;
      ovf_out_d = ovf_inc;
      for (int i = 0; i < P_FAN_NUM; i++) begin
        out_d[i*W +: W] = acc_inc[i];
        stall_d[i]      = (acc_inc[i] == '0);
      end
    end else if (xfer) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the small per-fan
  // arrays are register banks, not RAM, so they are reset along with the rest.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      ovf_q      <= '0;
      out_q      <= '0;
      stall_q    <= '0;
      ovf_out_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < P_FAN_NUM; i++) begin
        flt_cnt_q[i] <= '0;
        acc_q[i]     <= '0;
      end
    end else begin
      state_q    <= state_d;
      sync1_q    <= fan_speed;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      ovf_q      <= ovf_d;
      out_q      <= out_d;
      stall_q    <= stall_d;
      ovf_out_q  <= ovf_out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      for (int i = 0; i < P_FAN_NUM; i++) begin
        flt_cnt_q[i] <= flt_cnt_d[i];
        acc_q[i]     <= acc_d[i];
      end
    end
  end

  assign count_out     = out_q;
  assign count_stall   = stall_q;
  assign count_ovf     = ovf_out_q;
  assign count_overrun = overrun_q;
  assign count_valid   = valid_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Directed bench for fan_tach_monitor: a 16-bit instance and a 4-bit instance
// share one stimulus stream; the 4-bit one exercises saturation.
module tb_fan_tach_monitor;

  logic        aclk, areset, en, tick_1s, count_ready;
  logic [5:0]  fan_speed;

  logic [95:0] c16_out;
  logic [5:0]  c16_stall, c16_ovf;
  logic        c16_overrun, c16_valid;
  logic [23:0] c4_out;
  logic [5:0]  c4_stall, c4_ovf;
  logic        c4_overrun, c4_valid;

  int tests = 0;
  int fails = 0;

  fan_tach_monitor #(.P_FAN_NUM(6), .P_FILTER_LEN(4), .P_COUNT_WIDTH(16)) dut16 (
    .aclk(aclk), .areset(areset), .en(en), .tick_1s(tick_1s), .fan_speed(fan_speed),
    .count_out(c16_out), .count_stall(c16_stall), .count_ovf(c16_ovf),
    .count_overrun(c16_overrun), .count_valid(c16_valid), .count_ready(count_ready)
  );

  fan_tach_monitor #(.P_FAN_NUM(6), .P_FILTER_LEN(4), .P_COUNT_WIDTH(4)) dut4 (
    .aclk(aclk), .areset(areset), .en(en), .tick_1s(tick_1s), .fan_speed(fan_speed),
    .count_out(c4_out), .count_stall(c4_stall), .count_ovf(c4_ovf),
    .count_overrun(c4_overrun), .count_valid(c4_valid), .count_ready(count_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    step(1);
    tick_1s = 1'b0;
  endtask

  task automatic pulses(input int fan, input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      fan_speed[fan] = 1'b1;
      step(hi);
      fan_speed[fan] = 1'b0;
      step(lo);
    end
  endtask

  task automatic consume();
    count_ready = 1'b1;
    step(1);
    count_ready = 1'b0;
  endtask

  initial begin
    areset = 1'b1; en = 1'b0; tick_1s = 1'b0; count_ready = 1'b0; fan_speed = '0;

    // 1: reset with toggling pins, then ticks with en=0
    for (int k = 0; k < 10; k++) begin
      fan_speed = ~fan_speed;
      step(1);
    end
    check("rst_out",     128'(c16_out), 128'd0);
    check("rst_stall",   128'(c16_stall), 128'd0);
    check("rst_ovf",     128'(c16_ovf), 128'd0);
    check("rst_overrun", 128'(c16_overrun), 128'd0);
    check("rst_valid",   128'(c16_valid), 128'd0);
    fan_speed = '0;
    areset = 1'b0;
    step(3);
    tick();
    step(5);
    tick();
    step(2);
    check("idle_valid",  128'(c16_valid), 128'd0);

    // 2: ARMED discard, 10 clean pulses on fan 0
    en = 1'b1;
    step(2);
    pulses(0, 2, 8, 8);
    tick();
    check("armed_valid", 128'(c16_valid), 128'd0);
    pulses(0, 10, 8, 8);
    tick();
    check("p10_out",     128'(c16_out), 128'd10);
    check("p10_stall",   128'(c16_stall), 128'b111110);
    check("p10_valid",   128'(c16_valid), 128'd1);
    check("p10_ovf",     128'(c16_ovf), 128'd0);
    step(3);
    check("p10_hold",    128'(c16_out), 128'd10);
    consume();
    check("p10_taken",   128'(c16_valid), 128'd0);

    // 3: short glitches on fan 1 are rejected
    pulses(1, 5, 2, 6);
    step(4);
    tick();
    check("glitch_out",   128'(c16_out), 128'd0);
    check("glitch_stall", 128'(c16_stall), 128'b111111);
    consume();

    // 4: saturation in the 4-bit instance, then recovery
    pulses(2, 20, 8, 8);
    tick();
    check("sat16_out",   128'(c16_out), 128'd20 << 32);
    check("sat16_stall", 128'(c16_stall), 128'b111011);
    check("sat16_ovf",   128'(c16_ovf), 128'd0);
    check("sat4_out",    128'(c4_out), 128'hF00);
    check("sat4_ovf",    128'(c4_ovf), 128'b000100);
    consume();
    pulses(2, 3, 8, 8);
    tick();
    check("rec4_out",    128'(c4_out), 128'h300);
    check("rec4_ovf",    128'(c4_ovf), 128'd0);
    consume();

    // 5: overrun across two untaken publishes
    pulses(0, 3, 8, 8);
    tick();
    check("ovr1_out",     128'(c16_out), 128'd3);
    check("ovr1_overrun", 128'(c16_overrun), 128'd0);
    pulses(0, 7, 8, 8);
    tick();
    check("ovr2_out",     128'(c16_out), 128'd7);
    check("ovr2_overrun", 128'(c16_overrun), 128'd1);
    check("ovr2_valid",   128'(c16_valid), 128'd1);
    consume();
    check("ovr_taken_valid",   128'(c16_valid), 128'd0);
    check("ovr_taken_overrun", 128'(c16_overrun), 128'd0);

    // 6a: edge reaching the accumulator on the tick cycle counts in the closing window
    pulses(0, 2, 8, 8);
    fan_speed[0] = 1'b1;
    step(6);
    tick();
    check("edge_tick_out", 128'(c16_out), 128'd3);
    fan_speed[0] = 1'b0;
    consume();
    step(10);
    tick();
    check("edge_next_out",   128'(c16_out), 128'd0);
    check("edge_next_stall", 128'(c16_stall), 128'b111111);
    consume();

    // 6b: reset mid-window discards partial counts
    pulses(0, 4, 8, 8);
    en = 1'b0;
    areset = 1'b1;
    step(2);
    check("mid_rst_valid", 128'(c16_valid), 128'd0);
    check("mid_rst_out",   128'(c16_out), 128'd0);
    areset = 1'b0;
    en = 1'b1;
    step(2);
    tick();
    pulses(0, 2, 8, 8);
    tick();
    check("post_rst_out",   128'(c16_out), 128'd2);
    check("post_rst_valid", 128'(c16_valid), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
